// File: rtl/btn_conditioner.sv
// Push-button and slide-switch conditioner: 2-flop sync, counter debounce,
// press/release edge pulses and a per-button auto-repeat FSM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RPT_IDLE  | button not held (or not yet accepted); no repeat pending
// RPT_DELAY | button held; counting REPEAT_DELAY cycles to first repeat
// RPT_RATE  | button held; pulsing btn_repeat every REPEAT_RATE cycles
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 20000000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] btn_raw,
    input  logic       sw0_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] btn_repeat,
    output logic       sw0_level
);

    localparam int          NCH     = 5;
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RR_LAST = 32'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_e;

    // Channel 4 is the slide switch; channels 3..0 are the buttons.
    logic [NCH-1:0]       raw;
    logic [NCH-1:0]       meta_q;
    logic [NCH-1:0]       sync_q;
    logic [NCH-1:0]       level_q;
    logic [NCH-1:0]       level_d;
    logic [NCH-1:0][31:0] db_cnt_q;
    logic [NCH-1:0][31:0] db_cnt_d;
    logic [3:0]           press_d;
    logic [3:0]           release_d;
    logic [3:0]           press_q;
    logic [3:0]           release_q;

    assign raw = {sw0_raw, btn_raw};

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign press_d   =  level_d[3:0] & ~level_q[3:0];
    assign release_d = ~level_d[3:0] &  level_q[3:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            db_cnt_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The FSM reacts to the same edge that registers the press/release pulse,
    // so the first repeat lands exactly REPEAT_DELAY cycles after the press.
    for (genvar g = 0; g < 4; g++) begin : g_rpt
        rpt_state_e  state_q;
        logic [31:0] cnt_q;
        logic        rep_q;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (release_d[g]) begin
                    state_q <= RPT_IDLE;
                    cnt_q   <= '0;
                end else begin
                    case (state_q)
                        RPT_IDLE: begin
                            if (press_d[g]) begin
                                state_q <= RPT_DELAY;
                                cnt_q   <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (cnt_q == RD_LAST) begin
                                rep_q   <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= RPT_RATE;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        RPT_RATE: begin
                            if (cnt_q == RR_LAST) begin
                                rep_q <= 1'b1;
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            state_q <= RPT_IDLE;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_repeat[g] = rep_q;
    end

    assign btn_level   = level_q[3:0];
    assign sw0_level   = level_q[4];
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
